// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and DM requesters onto one memory port, DM priority with IF anti-starvation
module mem_port_arbiter #(
    parameter int XLEN          = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [3:0]      dm_be_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [XLEN-1:0] dm_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            busy_o,
    output logic            err_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t          r_state;
    logic            r_owner_dm;
    logic [3:0]      r_streak;
    logic            r_err;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [3:0]      r_mem_be;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;

    logic            w_pick_dm;
    logic [3:0]      w_streak_inc;
    logic            w_gnt;
    logic            w_rvalid;

    assign w_pick_dm    = dm_req_i && (!if_req_i || r_streak < 4'(MAX_DM_STREAK));
    assign w_streak_inc = (r_streak == 4'hF) ? r_streak : r_streak + 4'd1;
    assign w_gnt        = (r_state == ISSUE) && mem_gnt_i;
    assign w_rvalid     = (r_state == RESP) && mem_rvalid_i;

    assign if_gnt_o    = w_gnt && !r_owner_dm;
    assign dm_gnt_o    = w_gnt && r_owner_dm;
    assign if_rvalid_o = w_rvalid && !r_owner_dm;
    assign dm_rvalid_o = w_rvalid && r_owner_dm;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign busy_o      = (r_state != IDLE);
    assign err_o       = r_err;

    // Transaction FSM: arbitrate in IDLE, hold request until grant, wait for response; flag stray handshakes
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= IDLE;
            r_owner_dm  <= 1'b0;
            r_streak    <= 4'd0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if ((mem_rvalid_i && r_state != RESP) || (mem_gnt_i && r_state != ISSUE))
                r_err <= 1'b1;
            case (r_state)
                IDLE: if (if_req_i || dm_req_i) begin
                    r_state     <= ISSUE;
                    r_mem_req   <= 1'b1;
                    r_owner_dm  <= w_pick_dm;
                    r_mem_we    <= w_pick_dm && dm_we_i;
                    r_mem_be    <= w_pick_dm ? dm_be_i : 4'hF;
                    r_mem_addr  <= w_pick_dm ? dm_addr_i : if_addr_i;
                    r_mem_wdata <= w_pick_dm ? dm_wdata_i : '0;
                    r_streak    <= (w_pick_dm && if_req_i) ? w_streak_inc : 4'd0;
                end
                ISSUE: if (mem_gnt_i) begin
                    r_mem_req <= 1'b0;
                    r_state   <= RESP;
                end
                RESP: if (mem_rvalid_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [3:0]  dm_be_i = '0;
    logic [31:0] dm_addr_i = '0, dm_wdata_i = '0;
    logic        dm_gnt_o, dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        busy_o, err_o;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.XLEN(32), .MAX_DM_STREAK(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [5:0] exp_order;
        exp_order = 6'b101111;
        // reset state
        tick();
        settle();
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_be", 32'(mem_be_o), 32'd0);
        check("rst_gnts", {30'd0, if_gnt_o, dm_gnt_o}, 32'd0);
        rstn_i = 1'b1;

        // IF-only read
        tick();
        if_req_i = 1'b1; if_addr_i = 32'h100;
        settle();
        check("if_n_busy", 32'(busy_o), 32'd0);
        check("if_n_memreq", 32'(mem_req_o), 32'd0);
        tick();
        mem_gnt_i = 1'b1;
        settle();
        check("if_n1_memreq", 32'(mem_req_o), 32'd1);
        check("if_n1_addr", mem_addr_o, 32'h100);
        check("if_n1_we", 32'(mem_we_o), 32'd0);
        check("if_n1_be", 32'(mem_be_o), 32'hF);
        check("if_n1_gnt", 32'(if_gnt_o), 32'd1);
        check("if_n1_dmgnt", 32'(dm_gnt_o), 32'd0);
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        settle();
        check("if_n2_memreq", 32'(mem_req_o), 32'd0);
        check("if_n2_rvalid", 32'(if_rvalid_o), 32'd1);
        check("if_n2_rdata", if_rdata_o, 32'hDEADBEEF);
        check("if_n2_dmrvalid", 32'(dm_rvalid_o), 32'd0);
        check("if_n2_dmrdata", dm_rdata_o, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        check("if_n3_busy", 32'(busy_o), 32'd0);
        check("if_n3_rdata_gated", if_rdata_o, 32'd0);
        check("if_n3_err", 32'(err_o), 32'd0);

        // DM write with payload changed after arbitration
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011; dm_addr_i = 32'h2000; dm_wdata_i = 32'h1234;
        settle();
        check("dw_n_busy", 32'(busy_o), 32'd0);
        tick();
        dm_we_i = 1'b0; dm_be_i = 4'hC; dm_addr_i = 32'h9999; dm_wdata_i = 32'h5555;
        mem_gnt_i = 1'b1;
        settle();
        check("dw_n1_busy", 32'(busy_o), 32'd1);
        check("dw_we", 32'(mem_we_o), 32'd1);
        check("dw_be", 32'(mem_be_o), 32'h3);
        check("dw_addr", mem_addr_o, 32'h2000);
        check("dw_wdata", mem_wdata_o, 32'h1234);
        check("dw_gnt", {30'd0, if_gnt_o, dm_gnt_o}, 32'd1);
        tick();
        dm_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA;
        settle();
        check("dw_n2_busy", 32'(busy_o), 32'd1);
        check("dw_rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd1);
        check("dw_rdata", dm_rdata_o, 32'hAAAA);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        check("dw_n3_busy", 32'(busy_o), 32'd0);
        check("dw_n3_rvalid", 32'(dm_rvalid_o), 32'd0);

        // contention: DM first, IF's mem_req rises at N+4
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h3000;
        if_req_i = 1'b1; if_addr_i = 32'h400;
        tick();
        mem_gnt_i = 1'b1;
        settle();
        check("ct_first_dm", {30'd0, if_gnt_o, dm_gnt_o}, 32'd1);
        check("ct_first_addr", mem_addr_o, 32'h3000);
        tick();
        dm_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
        settle();
        check("ct_dm_rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd1);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        check("ct_n3_memreq", 32'(mem_req_o), 32'd0);
        tick();
        mem_gnt_i = 1'b1;
        settle();
        check("ct_n4_memreq", 32'(mem_req_o), 32'd1);
        check("ct_n4_addr", mem_addr_o, 32'h400);
        check("ct_n4_ifgnt", {30'd0, if_gnt_o, dm_gnt_o}, 32'd2);
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h88;
        settle();
        check("ct_if_rdata", if_rdata_o, 32'h88);
        tick();
        mem_rvalid_i = 1'b0;

        // starvation bound: DM,DM,DM,DM,IF,DM with both held
        dm_req_i = 1'b1; if_req_i = 1'b1; dm_addr_i = 32'h3000; if_addr_i = 32'h400;
        for (int i = 0; i < 6; i++) begin
            tick();
            mem_gnt_i = 1'b1;
            settle();
            check($sformatf("sv_grant%0d", i), {30'd0, if_gnt_o, dm_gnt_o},
                  exp_order[i] ? 32'd1 : 32'd2);
            tick();
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
            if (i == 5) begin
                dm_req_i = 1'b0; if_req_i = 1'b0;
            end
            tick();
            mem_rvalid_i = 1'b0;
        end
        settle();
        check("sv_idle", 32'(busy_o), 32'd0);

        // wait states: grant after 3 stall cycles
        if_req_i = 1'b1; if_addr_i = 32'h500;
        for (int i = 0; i < 3; i++) begin
            tick();
            if_addr_i = 32'hBAD0 + 32'(i);
            settle();
            check($sformatf("ws_stall%0d", i), {mem_req_o, if_gnt_o, mem_be_o, mem_addr_o[25:0]},
                  {2'b10, 4'hF, 26'h500});
        end
        tick();
        mem_gnt_i = 1'b1;
        settle();
        check("ws_gnt", {mem_req_o, if_gnt_o, mem_be_o, mem_addr_o[25:0]}, {2'b11, 4'hF, 26'h500});
        tick();
        if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        settle();
        check("ws_single_pulse", {30'd0, mem_req_o, if_gnt_o}, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        tick();
        settle();
        check("ws_no_extra", {30'd0, mem_req_o, busy_o}, 32'd0);
        check("ws_err", 32'(err_o), 32'd0);

        // reset during RESP abandons the transaction
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h6000;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        dm_req_i = 1'b0; mem_gnt_i = 1'b0;
        settle();
        check("rr_busy_before", 32'(busy_o), 32'd1);
        rstn_i = 1'b0;
        settle();
        check("rr_busy", 32'(busy_o), 32'd0);
        check("rr_addr", mem_addr_o, 32'd0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111;
        settle();
        check("rr_no_rvalid", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
        check("rr_no_rdata", dm_rdata_o, 32'd0);
        tick();
        mem_rvalid_i = 1'b0;
        rstn_i = 1'b1;
        tick();
        settle();
        check("rr_err", 32'(err_o), 32'd0);

        // stray rvalid in IDLE is sticky until reset
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        check("er_rvalid_set", 32'(err_o), 32'd1);
        check("er_no_fwd", {30'd0, if_rvalid_o, dm_rvalid_o}, 32'd0);
        tick();
        tick();
        check("er_sticky", 32'(err_o), 32'd1);
        rstn_i = 1'b0;
        settle();
        check("er_cleared", 32'(err_o), 32'd0);
        rstn_i = 1'b1;
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        settle();
        check("er_stray_gnt", {30'd0, err_o, busy_o}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
